// File: rtl/montgomery_exp.sv
// -----------------------------------------------------------------------------
// montgomery_exp
//
// Modular exponentiation controller computing result = X^E mod M with
// left-to-right binary square-and-multiply. It performs no arithmetic of its
// own: every product is delegated to an external Montgomery multiplier through
// a start/done handshake. The controller owns operand sequencing, the exponent
// bit scan and the entry into / exit from the Montgomery domain.
//
// Ports
//   clk          clock
//   resetn       synchronous, active-low reset
//   start        one-cycle pulse, captures operands while idle
//   in_x         base X (X < M)
//   in_e         exponent E, scanned MSB first over all E_BITS bits
//   in_m         odd modulus M
//   in_r         R mod M, R = 2^N (Montgomery form of 1)
//   in_r2        R^2 mod M (used to map X into the Montgomery domain)
//   result       X^E mod M, valid from the done pulse until the next start
//   done         one-cycle completion pulse
//   mont_start   one-cycle start pulse to the multiplier
//   mont_a/b     multiplier operands, held stable while a product is pending
//   mont_m       registered copy of the modulus for the multiplier
//   mont_result  multiplier product A*B*R^-1 mod M
//   mont_done    multiplier completion pulse
// -----------------------------------------------------------------------------
module montgomery_exp #(
  parameter int N      = 512,
  parameter int E_BITS = 512,
  parameter int CW     = 10
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [N-1:0]      in_x,
  input  logic [E_BITS-1:0] in_e,
  input  logic [N-1:0]      in_m,
  input  logic [N-1:0]      in_r,
  input  logic [N-1:0]      in_r2,
  output logic [N-1:0]      result,
  output logic              done,
  output logic              mont_start,
  output logic [N-1:0]      mont_a,
  output logic [N-1:0]      mont_b,
  output logic [N-1:0]      mont_m,
  input  logic [N-1:0]      mont_result,
  input  logic              mont_done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_SQ   = 3'd2;
  localparam logic [2:0] S_MUL  = 3'd3;
  localparam logic [2:0] S_POST = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic              waitPhase_q, waitPhase_d;
  logic [N-1:0]      xt_q, xt_d;
  logic [N-1:0]      acc_q, acc_d;
  logic [E_BITS-1:0] eReg_q, eReg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N-1:0]      result_q, result_d;
  logic              done_q, done_d;
  logic              montStart_q, montStart_d;
  logic [N-1:0]      montA_q, montA_d;
  logic [N-1:0]      montB_q, montB_d;
  logic [N-1:0]      montM_q, montM_d;

  logic [CW-1:0]     cntDec;
  logic [E_BITS-1:0] eShift;
  logic [2:0]        afterBit;

  // After a bit has been fully consumed the scan either continues with the
  // next square or, once every exponent bit is done, leaves the domain.
  assign cntDec   = cnt_q - CW'(1);
  assign eShift   = {eReg_q[E_BITS-2:0], 1'b0};
  assign afterBit = (cntDec != '0) ? S_SQ : S_POST;

  assign result     = result_q;
  assign done       = done_q;
  assign mont_start = montStart_q;
  assign mont_a     = montA_q;
  assign mont_b     = montB_q;
  assign mont_m     = montM_q;

  // Next-state logic. Each multiplying state has an ISSUE cycle (waitPhase=0)
  // that loads the operand registers and requests a start pulse, followed by a
  // WAIT phase (waitPhase=1) that only reacts to mont_done.
  always_comb begin
    state_d     = state_q;
    waitPhase_d = waitPhase_q;
    xt_d        = xt_q;
    acc_d       = acc_q;
    eReg_d      = eReg_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    done_d      = 1'b0;
    montStart_d = 1'b0;
    montA_d     = montA_q;
    montB_d     = montB_q;
    montM_d     = montM_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // The PRE operands (X, R^2) go straight into the operand registers,
          // so neither needs a separate holding register.
          montA_d     = in_x;
          montB_d     = in_r2;
          montM_d     = in_m;
          eReg_d      = in_e;
          acc_d       = in_r;
          cnt_d       = CW'(E_BITS);
          waitPhase_d = 1'b0;
          state_d     = S_PRE;
        end
      end

      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      S_PRE, S_SQ, S_MUL, S_POST: begin
        if (!waitPhase_q) begin
          case (state_q)
            S_SQ: begin
              montA_d = acc_q;
              montB_d = acc_q;
            end
            S_MUL: begin
              montA_d = acc_q;
              montB_d = xt_q;
            end
            S_POST: begin
              montA_d = acc_q;
              montB_d = {{(N-1){1'b0}}, 1'b1};
            end
            default: begin
            end
          endcase
          montStart_d = 1'b1;
          waitPhase_d = 1'b1;
        end else if (mont_done) begin
          waitPhase_d = 1'b0;
          case (state_q)
            S_PRE: begin
              xt_d    = mont_result;
              state_d = S_SQ;
            end
            S_SQ: begin
              acc_d = mont_result;
              // A set bit keeps the bit in place until MUL has consumed it.
              if (eReg_q[E_BITS-1]) begin
                state_d = S_MUL;
              end else begin
                eReg_d  = eShift;
                cnt_d   = cntDec;
                state_d = afterBit;
              end
            end
            S_MUL: begin
              acc_d   = mont_result;
              eReg_d  = eShift;
              cnt_d   = cntDec;
              state_d = afterBit;
            end
            default: begin
              result_d = mont_result;
              state_d  = S_FIN;
            end
          endcase
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      waitPhase_q <= 1'b0;
      xt_q        <= '0;
      acc_q       <= '0;
      eReg_q      <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
      montStart_q <= 1'b0;
      montA_q     <= '0;
      montB_q     <= '0;
      montM_q     <= '0;
    end else begin
      state_q     <= state_d;
      waitPhase_q <= waitPhase_d;
      xt_q        <= xt_d;
      acc_q       <= acc_d;
      eReg_q      <= eReg_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      done_q      <= done_d;
      montStart_q <= montStart_d;
      montA_q     <= montA_d;
      montB_q     <= montB_d;
      montM_q     <= montM_d;
    end
  end

endmodule

// File: tb/tb_montgomery_exp.sv
// -----------------------------------------------------------------------------
// tb_montgomery_exp
//
// Bench for montgomery_exp. A behavioural Montgomery multiplier answers the
// controller's requests after a configurable latency. The stimulus process
// pushes the expected result and multiplier pulse count of every accepted
// exponentiation into a queue; a separate monitor pops and compares on each
// done pulse. The headline runs use a 10-cycle multiplier; the longer runs use
// a shorter latency so that the whole session stays within a modest cycle
// count.
// -----------------------------------------------------------------------------
module tb_montgomery_exp;

  localparam int N      = 512;
  localparam int E_BITS = 512;
  localparam int CW     = 10;
  localparam int WAIT_LIMIT = 30000;

  typedef struct {
    logic [N-1:0] res;
    int           pulses;
    string        name;
  } expect_t;

  logic              clk = 1'b0;
  logic              resetn;
  logic              start;
  logic [N-1:0]      inX;
  logic [E_BITS-1:0] inE;
  logic [N-1:0]      inM;
  logic [N-1:0]      inR;
  logic [N-1:0]      inR2;
  logic [N-1:0]      result;
  logic              done;
  logic              montStart;
  logic [N-1:0]      montA;
  logic [N-1:0]      montB;
  logic [N-1:0]      montM;
  logic [N-1:0]      montResult;
  logic              montDone;

  int      checks     = 0;
  int      failures   = 0;
  int      pulseCount = 0;
  int      mulLatency = 10;
  int      resetEpoch = 0;
  logic    prevDone   = 1'b0;
  expect_t sb[$];

  logic [N-1:0] modelA;
  logic [N-1:0] modelB;
  logic [N-1:0] modelRes;
  int           modelEpoch;
  logic         modelStable;

  always #5 clk = ~clk;

  montgomery_exp #(.N(N), .E_BITS(E_BITS), .CW(CW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .in_x        (inX),
    .in_e        (inE),
    .in_m        (inM),
    .in_r        (inR),
    .in_r2       (inR2),
    .result      (result),
    .done        (done),
    .mont_start  (montStart),
    .mont_a      (montA),
    .mont_b      (montB),
    .mont_m      (montM),
    .mont_result (montResult),
    .mont_done   (montDone)
  );

  // Interleaved bit-serial Montgomery product a*b*2^-N mod m.
  function automatic logic [N-1:0] montMul(input logic [N-1:0] a,
                                           input logic [N-1:0] b,
                                           input logic [N-1:0] m);
    logic [N+1:0] u;
    u = '0;
    for (int i = 0; i < N; i++) begin
      if (a[i]) u = u + {2'b00, b};
      if (u[0]) u = u + {2'b00, m};
      u = u >> 1;
    end
    if (u >= {2'b00, m}) u = u - {2'b00, m};
    return u[N-1:0];
  endfunction

  // Plain square-and-multiply reference using ordinary modular reduction.
  function automatic logic [N-1:0] refModExp(input logic [N-1:0] x,
                                             input logic [E_BITS-1:0] e,
                                             input logic [N-1:0] m);
    logic [2*N-1:0] mw;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] prod;
    mw  = {{N{1'b0}}, m};
    acc = {{(2*N-1){1'b0}}, 1'b1} % mw;
    for (int i = E_BITS - 1; i >= 0; i--) begin
      prod = acc * acc;
      acc  = prod % mw;
      if (e[i]) begin
        prod = acc * {{N{1'b0}}, x};
        acc  = prod % mw;
      end
    end
    return acc[N-1:0];
  endfunction

  function automatic void computeRs(input logic [N-1:0] m,
                                    output logic [N-1:0] r,
                                    output logic [N-1:0] r2);
    logic [2*N-1:0] mw;
    logic [2*N-1:0] big;
    logic [2*N-1:0] t;
    mw     = {{N{1'b0}}, m};
    big    = '0;
    big[N] = 1'b1;
    t      = big % mw;
    r      = t[N-1:0];
    t      = (t * t) % mw;
    r2     = t[N-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [N-1:0] actual,
                             input logic [N-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input string name, input logic [N-1:0] x,
                               input logic [E_BITS-1:0] e, input logic [N-1:0] m,
                               input logic [N-1:0] r, input logic [N-1:0] r2,
                               input logic [N-1:0] expRes, input int expPulses,
                               input bit accepted);
    expect_t item;
    inX  = x;
    inE  = e;
    inM  = m;
    inR  = r;
    inR2 = r2;
    start = 1'b1;
    if (accepted) begin
      item.res    = expRes;
      item.pulses = expPulses;
      item.name   = name;
      sb.push_back(item);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int cycles = 0;
    while (!done && cycles < WAIT_LIMIT) begin
      @(negedge clk);
      cycles++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout: actual=no done required=done within %0d cycles", name, WAIT_LIMIT);
    end
  endtask

  task automatic waitPulses(input int n);
    int seen = 0;
    int cycles = 0;
    while (seen < n && cycles < WAIT_LIMIT) begin
      @(negedge clk);
      cycles++;
      if (montStart) seen++;
    end
    if (seen < n) begin
      checks++;
      failures++;
      $display("[TB] FAIL pulse_wait_timeout: actual=%0d required=%0d", seen, n);
    end
  endtask

  // Marks every reset so that a product pending across a reset is dropped.
  always @(posedge clk) begin
    if (!resetn) resetEpoch++;
  end

  // Behavioural multiplier: latches operands on the start pulse, answers
  // mulLatency cycles later and verifies operands did not move meanwhile.
  initial begin
    montDone   = 1'b0;
    montResult = '0;
    forever begin
      @(negedge clk);
      montDone = 1'b0;
      if (montStart) begin
        modelA      = montA;
        modelB      = montB;
        modelRes    = montMul(montA, montB, montM);
        modelEpoch  = resetEpoch;
        modelStable = 1'b1;
        for (int i = 0; i < mulLatency - 1; i++) begin
          @(negedge clk);
          if (resetEpoch == modelEpoch && (montA !== modelA || montB !== modelB))
            modelStable = 1'b0;
        end
        if (resetEpoch == modelEpoch) begin
          checkOutput("wait_operands_stable", N'(modelStable), N'(1));
          montResult = modelRes;
          montDone   = 1'b1;
        end
      end
    end
  end

  // Scoreboard monitor: counts multiplier pulses and checks each done.
  initial begin
    expect_t item;
    forever begin
      @(negedge clk);
      if (montStart) pulseCount++;
      if (done) begin
        checkOutput("done_width", N'(prevDone), '0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_done: actual=done pulse required=no pulse");
        end else begin
          item = sb.pop_front();
          checkOutput({item.name, "_result"}, result, item.res);
          checkOutput({item.name, "_pulses"}, N'(pulseCount), N'(item.pulses));
        end
        pulseCount = 0;
      end
      prevDone = done;
    end
  end

  initial begin
    logic [N-1:0]      x;
    logic [N-1:0]      m;
    logic [N-1:0]      r;
    logic [N-1:0]      r2;
    logic [E_BITS-1:0] e;

    resetn = 1'b0;
    start  = 1'b0;
    inX    = '0;
    inE    = '0;
    inM    = '0;
    inR    = '0;
    inR2   = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_result",     result,         '0);
    checkOutput("reset_done",       N'(done),       '0);
    checkOutput("reset_mont_start", N'(montStart),  '0);
    checkOutput("reset_mont_a",     montA,          '0);
    checkOutput("reset_mont_b",     montB,          '0);
    checkOutput("reset_mont_m",     montM,          '0);
    resetn = 1'b1;
    @(negedge clk);

    // 2^5 mod 13 = 6; R mod 13 = 9, R^2 mod 13 = 3; 1+512+2+1 products.
    mulLatency = 10;
    applyStimulus("basic", 2, 5, 13, 9, 3, 6, 516, 1'b1);
    waitPulses(100);
    applyStimulus("busy", 3, 7, 13, 9, 3, '0, 0, 1'b0);
    waitDone("basic");

    // Start issued in the same cycle as the previous done pulse.
    mulLatency = 3;
    applyStimulus("zero_exp", 7, 0, 13, 9, 3, 1, 514, 1'b1);
    waitDone("zero_exp");
    @(negedge clk);

    applyStimulus("unit_exp", 2, 1, 13, 9, 3, 2, 515, 1'b1);
    waitDone("unit_exp");
    @(negedge clk);

    e = '1;
    applyStimulus("all_ones", 2, e, 13, 9, 3, refModExp(2, e, 13), 1026, 1'b1);
    waitDone("all_ones");
    @(negedge clk);

    // Pulse 512 of E=5 is the MUL step; reset lands inside its wait.
    applyStimulus("aborted", 2, 5, 13, 9, 3, 6, 516, 1'b1);
    waitPulses(512);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    sb.delete();
    pulseCount = 0;
    checkOutput("abort_done",       N'(done),      '0);
    checkOutput("abort_result",     result,        '0);
    checkOutput("abort_mont_start", N'(montStart), '0);
    checkOutput("abort_mont_a",     montA,         '0);
    repeat (2) @(negedge clk);

    mulLatency = 10;
    applyStimulus("after_reset", 2, 5, 13, 9, 3, 6, 516, 1'b1);
    waitDone("after_reset");
    @(negedge clk);

    mulLatency = 3;
    for (int k = 0; k < 6; k++) begin
      for (int w = 0; w < N / 32; w++) begin
        m[w*32 +: 32] = $urandom;
        x[w*32 +: 32] = $urandom;
        e[w*32 +: 32] = $urandom;
      end
      m[0]   = 1'b1;
      m[N-1] = 1'b1;
      x      = x % m;
      computeRs(m, r, r2);
      applyStimulus($sformatf("random%0d", k), x, e, m, r, r2,
                    refModExp(x, e, m), 2 + E_BITS + $countones(e), 1'b1);
      waitDone($sformatf("random%0d", k));
      @(negedge clk);
    end

    repeat (20) @(negedge clk);
    checkOutput("scoreboard_empty", N'(sb.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
